// File: rtl/vga_chunk_pkg.sv
// vga_chunk_pkg: shared geometry and state encoding for the line chunk sequencer
package vga_chunk_pkg;
  localparam int LINE_W     = 480;
  localparam int CHUNK_W    = 16;
  localparam int NUM_CHUNKS = LINE_W / CHUNK_W;
  localparam int MEM_DEPTH  = 960;
  localparam int ADDR_W     = 10;
  localparam int IDX_W      = $clog2(NUM_CHUNKS);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-N counter with enable, synchronous clear and async active-low reset
module wrap_counter #(
  parameter int N = 30,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= (cnt == W'(N - 1)) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/line_chunk_sequencer.sv
// line_chunk_sequencer: streams one captured pixel line as CHUNK_W words into a
// ping-pong line memory, honouring wr_ready backpressure and pulsing line_done per line
module line_chunk_sequencer
  import vga_chunk_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_valid,
  output logic               line_ready,
  input  logic [LINE_W-1:0]  line_data,
  input  logic               flush,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [CHUNK_W-1:0] wr_data,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               line_done,
  output logic               busy
);
  state_t r_state, w_next;
  logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] r_line_buf;
  logic [IDX_W-1:0] w_chunk_idx;
  logic w_accept, w_xfer, w_last;
  assign line_ready = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign line_done  = r_state == DONE;
  assign wr_en      = r_state == STREAM;
  assign w_accept   = line_valid && line_ready && !flush;
  assign w_xfer     = wr_en && wr_ready;
  assign w_last     = w_chunk_idx == IDX_W'(NUM_CHUNKS - 1);
  // Outputs are decoded from registers only, so wr_* hold steady under backpressure
  assign wr_data    = r_line_buf[w_chunk_idx];
  always_comb begin
    w_next = r_state;
    w_next = flush ? IDLE :
             (r_state == IDLE)   ? (w_accept ? STREAM : IDLE) :
             (r_state == STREAM) ? ((w_xfer && w_last) ? DONE : STREAM) :
             IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_line_buf <= '0;
    else if (w_accept) r_line_buf <= line_data;
  end
  wrap_counter #(.N(NUM_CHUNKS), .W(IDX_W)) u_chunk_idx (
    .clk(clk), .rst_n(rst_n), .en(w_xfer), .clr(flush || w_accept), .cnt(w_chunk_idx)
  );
  wrap_counter #(.N(MEM_DEPTH), .W(ADDR_W)) u_wr_addr (
    .clk(clk), .rst_n(rst_n), .en(w_xfer), .clr(flush), .cnt(wr_addr)
  );
endmodule

// File: tb/tb_line_chunk_sequencer.sv
// tb_line_chunk_sequencer: scoreboard bench; expected writes are queued when a line is
// offered and popped as the sequencer transfers chunks
module tb_line_chunk_sequencer;
  logic         clk = 0;
  logic         rst_n = 1;
  logic         line_valid = 0;
  logic         line_ready;
  logic [479:0] line_data = '0;
  logic         flush = 0;
  logic         wr_en;
  logic         wr_ready = 1;
  logic [15:0]  wr_data;
  logic [9:0]   wr_addr;
  logic         line_done;
  logic         busy;

  typedef struct {int addr; int data;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  int m_addr = 0;
  int en_cnt = 0, done_cnt = 0;

  line_chunk_sequencer dut (
    .clk(clk), .rst_n(rst_n), .line_valid(line_valid), .line_ready(line_ready),
    .line_data(line_data), .flush(flush), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .line_done(line_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) en_cnt++;
      if (line_done) done_cnt++;
      if (wr_en && wr_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_data", int'(wr_data), e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [479:0] mk(input logic [15:0] base);
    logic [479:0] v;
    for (int k = 0; k < 30; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic expect_line(input logic [15:0] base);
    for (int k = 0; k < 30; k++) begin
      sb.push_back('{addr: m_addr, data: int'(base) + k});
      m_addr = (m_addr + 1) % 960;
    end
  endtask

  task automatic send_line(input logic [15:0] base);
    int t = 0;
    while (!line_ready && t < 200) begin tick; t++; end
    if (!line_ready) chk("ready_timeout", 0, 1);
    line_valid = 1;
    line_data = mk(base);
    expect_line(base);
    tick;
    line_valid = 0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while ((busy || sb.size() != 0) && t < 500) begin tick; t++; end
    if (busy || sb.size() != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_done"}, int'(line_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(line_ready), 1);
  endtask

  initial begin
    int c, d, a0, done0;
    // reset at start, and asynchronously mid-line
    #2 rst_n = 0;
    #1 chk_reset_outputs("rst0");
    chk("rst0_wr_data", int'(wr_data), 0);
    tick; tick;
    rst_n = 1;
    send_line(16'h0100);
    tick; tick; tick;
    #3 rst_n = 0;
    #1 chk_reset_outputs("rst_mid");
    sb.delete();
    m_addr = 0;
    tick;
    rst_n = 1;
    tick;
    // single line, no backpressure
    en_cnt = 0; done_cnt = 0;
    send_line(16'h0100);
    chk("t2_first_en", int'(wr_en), 1);
    c = 1;
    while (!line_done && c < 60) begin tick; c++; end
    chk("t2_done_cycle", c, 31);
    tick;
    chk("t2_done_pulse", int'(line_done), 0);
    chk("t2_en_cycles", en_cnt, 30);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_sb_left", sb.size(), 0);
    // backpressure on chunk 5
    en_cnt = 0; done_cnt = 0;
    a0 = m_addr;
    send_line(16'h0100);
    repeat (5) tick;
    wr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_en", int'(wr_en), 1);
      chk("t3_hold_addr", int'(wr_addr), a0 + 5);
      chk("t3_hold_data", int'(wr_data), 16'h0105);
      tick;
    end
    wr_ready = 1;
    wait_idle;
    chk("t3_en_cycles", en_cnt, 33);
    chk("t3_done_cnt", done_cnt, 1);
    // 33 back-to-back lines from address 0
    flush = 1;
    tick;
    flush = 0;
    m_addr = 0;
    chk("t4_flush_addr", int'(wr_addr), 0);
    done_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      if (i == 32) begin
        d = 0;
        while (busy && d < 100) begin tick; d++; end
        chk("t4_wrap_addr", int'(wr_addr), 0);
      end
      send_line(16'(i << 8));
    end
    wait_idle;
    chk("t4_done_cnt", done_cnt, 33);
    // flush when chunk 10 transfers
    done_cnt = 0;
    send_line(16'h0A00);
    repeat (10) tick;
    flush = 1;
    tick;
    flush = 0;
    sb.delete();
    m_addr = 0;
    chk("t5_wr_en", int'(wr_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_addr", int'(wr_addr), 0);
    chk("t5_done", int'(line_done), 0);
    repeat (3) tick;
    chk("t5_no_done", done_cnt, 0);
    send_line(16'h0B00);
    chk("t5_restart_addr", int'(wr_addr), 0);
    wait_idle;
    // line_valid held across a whole line
    done_cnt = 0;
    line_valid = 1;
    line_data = mk(16'h0C00);
    expect_line(16'h0C00);
    tick;
    line_data = mk(16'h0D00);
    expect_line(16'h0D00);
    c = 0; d = -1;
    while (!line_ready && c < 100) begin
      if (line_done) d = c;
      tick;
      c++;
    end
    chk("t6_ready_low_cycles", c, 31);
    chk("t6_done_before_accept", d, 30);
    done0 = done_cnt;
    tick;
    line_valid = 0;
    chk("t6_second_accept", int'(busy), 1);
    wait_idle;
    chk("t6_done_cnt", done_cnt, done0 + 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
